// File: rtl/multiplexer_pkg.sv
// Shared defaults and lane type for the N-to-1 multiplexer and its 2:1 cell.
package multiplexer_pkg;

    localparam int MUX_N_IN   = 16;
    localparam int MUX_DATA_W = 1;
    localparam int MUX_SEL_W  = $clog2(MUX_N_IN);

    typedef logic [MUX_DATA_W-1:0] lane_t;

endpackage : multiplexer_pkg

// File: rtl/multiplexer_mux2.sv
// 2:1 combinational cell; sel_i = 1 picks b_i (the odd, higher-numbered lane).
module multiplexer_mux2 #(
    parameter int DATA_W = multiplexer_pkg::MUX_DATA_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sel_i,
    output logic [DATA_W-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule : multiplexer_mux2

// File: rtl/multiplexer.sv
// N-to-1 lane selector: a log2(N_IN)-level mux2 tree gives the combinational
// result, and a single register stage provides out_q/out_valid.
module multiplexer
    import multiplexer_pkg::*;
#(
    parameter int N_IN   = MUX_N_IN,
    parameter int DATA_W = MUX_DATA_W,
    parameter int SEL_W  = $clog2(N_IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_IN*DATA_W-1:0]   in,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    output logic [DATA_W-1:0]        out,
    output logic [DATA_W-1:0]        out_q,
    output logic                     out_valid
);

    localparam int LVL = $clog2(N_IN);

    logic [DATA_W-1:0] tree_y;
    logic              sel_oor;
    logic [DATA_W-1:0] data_d, data_q;
    logic              valid_d, valid_q;

    // Level j halves the lane count, steered by sel[j]; level 0 pairs adjacent lanes.
    for (genvar j = 0; j < LVL; j++) begin : g_lvl
        localparam int W = N_IN >> (j + 1);
        logic [2*W*DATA_W-1:0] x;
        logic [W*DATA_W-1:0]   y;

        if (j == 0) begin : g_src
            assign x = in;
        end else begin : g_src
            assign x = g_lvl[j-1].y;
        end

        for (genvar m = 0; m < W; m++) begin : g_cell
            multiplexer_mux2 #(.DATA_W(DATA_W)) u_mux2 (
                .a_i  (x[(2*m)*DATA_W +: DATA_W]),
                .b_i  (x[(2*m+1)*DATA_W +: DATA_W]),
                .sel_i(sel[j]),
                .y_o  (y[m*DATA_W +: DATA_W])
            );
        end
    end

    assign tree_y = g_lvl[LVL-1].y;

    // A select wider than the tree can address nonexistent lanes; those read as zero.
    if (SEL_W > LVL) begin : g_oor
        assign sel_oor = |sel[SEL_W-1:LVL];
    end else begin : g_no_oor
        assign sel_oor = 1'b0;
    end

    assign out = sel_oor ? '0 : tree_y;

    // Valid-only capture: every in_valid beat is taken, no ready/backpressure.
    // out_valid marks the cycle after a capture; out_q holds across idle cycles.
    always_comb begin
        data_d  = data_q;
        valid_d = in_valid;
        if (in_valid) begin
            data_d = out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_q     = data_q;
    assign out_valid = valid_q;

endmodule : multiplexer

// File: tb/tb_multiplexer.sv
// Directed bench for the default 16x1 mux, a 4x8 wide mux and a 4x8 mux with
// an oversized select, covering combinational, registered and reset behaviour.
module tb_multiplexer;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_d;
    logic [3:0]  sel_d;
    logic        in_valid;
    logic        out_d, out_q_d, out_valid_d;

    logic [31:0] in_w;
    logic [1:0]  sel_w;
    logic [7:0]  out_w, out_q_w;
    logic        out_valid_w;

    logic [2:0]  sel_x;
    logic [7:0]  out_x, out_q_x;
    logic        out_valid_x;

    int n_vec;
    int n_err;

    multiplexer u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in_d),
        .sel      (sel_d),
        .in_valid (in_valid),
        .out      (out_d),
        .out_q    (out_q_d),
        .out_valid(out_valid_d)
    );

    multiplexer #(.N_IN(4), .DATA_W(8)) u_wide (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in_w),
        .sel      (sel_w),
        .in_valid (in_valid),
        .out      (out_w),
        .out_q    (out_q_w),
        .out_valid(out_valid_w)
    );

    multiplexer #(.N_IN(4), .DATA_W(8), .SEL_W(3)) u_oor (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in_w),
        .sel      (sel_x),
        .in_valid (in_valid),
        .out      (out_x),
        .out_q    (out_q_x),
        .out_valid(out_valid_x)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] wide_exp [4];
        logic [7:0] oor_exp [8];
        wide_exp = '{8'haa, 8'hbb, 8'hcc, 8'hdd};
        oor_exp  = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'h00, 8'h00, 8'h00, 8'h00};
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_d     = 16'h3f0a;
        sel_d    = 4'd0;
        in_w     = 32'hddccbbaa;
        sel_w    = 2'd0;
        sel_x    = 3'd0;
        #1;
        check("reset_out_q", {31'd0, out_q_d}, 32'd0);
        check("reset_out_valid", {31'd0, out_valid_d}, 32'd0);
        check("reset_wide_out_q", {24'd0, out_q_w}, 32'd0);

        // Combinational path, no clock edge between steps (clk edges at 5,15,...)
        sel_d = 4'd0;  #1; check("comb_sel0", {31'd0, out_d}, 32'd0);
        #4;
        sel_d = 4'd1;  #1; check("comb_sel1", {31'd0, out_d}, 32'd1);
        #4;
        sel_d = 4'd6;  #1; check("comb_sel6", {31'd0, out_d}, 32'd0);
        #4;
        sel_d = 4'd12; #1; check("comb_sel12", {31'd0, out_d}, 32'd1);

        // One-hot sweep of every lane against every select
        for (int k = 0; k < 16; k++) begin
            for (int s = 0; s < 16; s++) begin
                in_d  = 16'd1 << k;
                sel_d = s[3:0];
                #1;
                check($sformatf("sweep_k%0d_s%0d", k, s), {31'd0, out_d}, (s == k) ? 32'd1 : 32'd0);
            end
        end

        for (int s = 0; s < 4; s++) begin
            sel_w = s[1:0];
            #1;
            check($sformatf("wide_sel%0d", s), {24'd0, out_w}, {24'd0, wide_exp[s]});
        end
        for (int s = 0; s < 8; s++) begin
            sel_x = s[2:0];
            #1;
            check($sformatf("oor_sel%0d", s), {24'd0, out_x}, {24'd0, oor_exp[s]});
        end

        // Registered path
        in_d  = 16'h3f0a;
        sel_w = 2'd2;
        @(negedge clk);
        check("held_in_reset_q", {31'd0, out_q_d}, 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        sel_d    = 4'd1;
        @(negedge clk);
        check("beat1_out_q", {31'd0, out_q_d}, 32'd1);
        check("beat1_out_valid", {31'd0, out_valid_d}, 32'd1);
        check("beat1_wide_q", {24'd0, out_q_w}, 32'h000000cc);
        sel_d = 4'd12;
        @(negedge clk);
        check("beat2_out_q", {31'd0, out_q_d}, 32'd1);
        check("beat2_out_valid", {31'd0, out_valid_d}, 32'd1);
        in_valid = 1'b0;
        sel_d    = 4'd0;
        @(negedge clk);
        check("idle_out_q_hold", {31'd0, out_q_d}, 32'd1);
        check("idle_out_valid", {31'd0, out_valid_d}, 32'd0);
        in_valid = 1'b1;
        @(negedge clk);
        check("beat3_out_q", {31'd0, out_q_d}, 32'd0);
        check("beat3_out_valid", {31'd0, out_valid_d}, 32'd1);
        in_valid = 1'b0;
        sel_d    = 4'd12;
        @(negedge clk);
        check("idle2_out_q_hold", {31'd0, out_q_d}, 32'd0);
        check("idle2_out_valid", {31'd0, out_valid_d}, 32'd0);
        in_valid = 1'b1;
        @(negedge clk);
        check("beat4_out_q", {31'd0, out_q_d}, 32'd1);
        check("beat4_out_valid", {31'd0, out_valid_d}, 32'd1);

        // Asynchronous reset between edges, with valid beats still presented
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_q", {31'd0, out_q_d}, 32'd0);
        check("async_rst_out_valid", {31'd0, out_valid_d}, 32'd0);
        sel_d = 4'd0; #1; check("rst_comb_sel0", {31'd0, out_d}, 32'd0);
        sel_d = 4'd1; #1; check("rst_comb_sel1", {31'd0, out_d}, 32'd1);
        @(negedge clk);
        check("rst_hold_out_q", {31'd0, out_q_d}, 32'd0);
        check("rst_hold_out_valid", {31'd0, out_valid_d}, 32'd0);

        // First capture after release
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_out_q", {31'd0, out_q_d}, 32'd1);
        check("post_rst_out_valid", {31'd0, out_valid_d}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_multiplexer
